// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
// Holds the FSM state encoding, the command layout and the fixed response values.
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_cmd_t;

    localparam logic [7:0] RSP_TIMEOUT_DATA = 8'hFF;
    localparam logic [7:0] RSP_WRITE_DATA   = 8'h00;
    localparam int         CMD_WIDTH        = 16;

    // Reinterpret a raw 16-bit command word as its fields.
    function automatic i2c_cmd_t cmd_unpack(input logic [CMD_WIDTH-1:0] raw);
        i2c_cmd_t cmd;
        cmd.rw   = raw[15];
        cmd.addr = raw[14:8];
        cmd.data = raw[7:0];
        return cmd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
// A push into a full FIFO is refused even when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (count_r == CNT_DEPTH);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;

    // Storage array write port; contents need no reset since count gates reads.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Queues I2C byte commands and drives the master's NEWMSG/clrNM handshake one
// transaction at a time, returning one response (or a timeout error) per command.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CMD_VALID,
    input  logic [15:0]   CMD_DATA,
    output logic          CMD_READY,
    output logic          RSP_VALID,
    output logic [7:0]    RSP_DATA,
    output logic          RSP_ERR,
    input  logic          RSP_READY,
    output logic [7:0]    I2C_MOSI,
    output logic [6:0]    I2C_SLAVE,
    output logic          I2C_RW,
    output logic          I2C_NEWMSG,
    input  logic          I2C_DONE,
    input  logic [7:0]    I2C_MISO,
    output logic          BUSY,
    output logic [CW-1:0] COUNT
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1'b1);

    seq_state_t        state_r;
    seq_state_t        state_nxt_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [15:0]       fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    i2c_cmd_t          head_s;
    logic              timeout_s;
    logic              rsp_hs_s;
    logic [TW-1:0]     to_cnt_r;
    logic              newmsg_r;
    logic              rsp_valid_r;
    logic [7:0]        rsp_data_r;
    logic              rsp_err_r;
    logic [7:0]        mosi_r;
    logic [6:0]        slave_r;
    logic              rw_r;

    assign fifo_push_s = CMD_VALID && !fifo_full_s;

    sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push_s),
        .push_data (CMD_DATA),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign head_s    = cmd_unpack(fifo_head_s);
    assign timeout_s = (to_cnt_r == TO_LAST);
    assign rsp_hs_s  = rsp_valid_r && RSP_READY;

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and FIFO pop request.
    always_comb begin
        state_nxt_s = state_r;
        fifo_pop_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = SETUP;
                    fifo_pop_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: state_nxt_s = WAIT;
            WAIT: begin
                if (I2C_DONE || timeout_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand, NEWMSG, timeout and response registers; DONE only counts in WAIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt_r    <= {TW{1'b0}};
            newmsg_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
            mosi_r      <= 8'h00;
            slave_r     <= 7'h00;
            rw_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fifo_pop_s) begin
                        mosi_r  <= head_s.data;
                        slave_r <= head_s.addr;
                        rw_r    <= head_s.rw;
                    end
                end
                SETUP: begin
                    newmsg_r <= 1'b1;
                    to_cnt_r <= {TW{1'b0}};
                end
                WAIT: begin
                    if (I2C_DONE) begin
                        newmsg_r    <= 1'b0;
                        rsp_data_r  <= rw_r ? I2C_MISO : RSP_WRITE_DATA;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end else if (timeout_s) begin
                        newmsg_r    <= 1'b0;
                        rsp_data_r  <= RSP_TIMEOUT_DATA;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                    end else if (to_cnt_r != TO_LIMIT) begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    newmsg_r <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_READY  = !fifo_full_s;
    assign RSP_VALID  = rsp_valid_r;
    assign RSP_DATA   = rsp_data_r;
    assign RSP_ERR    = rsp_err_r;
    assign I2C_MOSI   = mosi_r;
    assign I2C_SLAVE  = slave_r;
    assign I2C_RW     = rw_r;
    assign I2C_NEWMSG = newmsg_r;
    assign BUSY       = (state_r != IDLE) || !fifo_empty_s;
    assign COUNT      = fifo_count_s;

endmodule
